// File: rtl/result_upload.sv
// Latency-sample log in block RAM, served to the HPS as MAGIC, {overflow,count}, then samples.
// Read latency: 3 edges from ioctl_rd to ioctl_wait low; reads arriving while ioctl_wait is high are ignored.
module result_upload #(
  parameter int          DEPTH        = 1024,
  parameter logic [15:0] UPLOAD_INDEX = 16'd1,
  parameter logic [15:0] MAGIC        = 16'h4C41
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_wr,
  input  logic [15:0] sample_data,
  input  logic        clear,
  output logic [14:0] count,
  output logic        overflow,
  input  logic        ioctl_upload,
  input  logic [15:0] ioctl_index,
  input  logic        ioctl_rd,
  input  logic [26:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [14:0] DEPTH_C = 15'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  typedef enum logic [1:0] {SEL_MAGIC, SEL_STAT, SEL_RAM, SEL_ZERO} sel_t;

  logic [15:0] mem [DEPTH];
  logic [15:0] ram_q;
  logic        active;
  logic        log_wr;
  logic        unused_addr_bit;

  state_t      state;
  sel_t        sel_q;
  logic [25:0] word_q;
  logic [25:0] ram_idx;
  logic [15:0] stat_q;

  assign active          = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign log_wr          = sample_wr && !active && !clear && (count != DEPTH_C);
  assign ram_idx         = word_q - 26'd2;
  assign unused_addr_bit = ioctl_addr[0];

  // RAM kept free of reset so it maps onto block RAM; count alone marks valid data.
  always_ff @(posedge clk) begin
    if (log_wr)
      mem[count[AW-1:0]] <= sample_data;
  end

  always_ff @(posedge clk) begin
    ram_q <= mem[ram_idx[AW-1:0]];
  end

  // The log is frozen while the HPS uploads: writes are dropped (and flagged), clear is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (active) begin
      if (sample_wr)
        overflow <= 1'b1;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (sample_wr) begin
      if (count == DEPTH_C)
        overflow <= 1'b1;
      else
        count <= count + 15'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ioctl_wait <= 1'b0;
      ioctl_din  <= 16'h0000;
      word_q     <= '0;
      sel_q      <= SEL_ZERO;
      stat_q     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (ioctl_rd && active) begin
            word_q     <= ioctl_addr[26:1];
            ioctl_wait <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          stat_q <= {overflow, count};
          // Full-width compare against count keeps out-of-range words from aliasing into RAM.
          if (word_q == 26'd0)
            sel_q <= SEL_MAGIC;
          else if (word_q == 26'd1)
            sel_q <= SEL_STAT;
          else if (ram_idx < {11'd0, count})
            sel_q <= SEL_RAM;
          else
            sel_q <= SEL_ZERO;
          state <= DONE;
        end
        DONE: begin
          case (sel_q)
            SEL_MAGIC: ioctl_din <= MAGIC;
            SEL_STAT:  ioctl_din <= stat_q;
            SEL_RAM:   ioctl_din <= ram_q;
            default:   ioctl_din <= 16'h0000;
          endcase
          ioctl_wait <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          ioctl_wait <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
